// File: rtl/axis_tdest_scheduler_if.sv
// AXI-Stream link used on both sides of the tdest scheduler.
// tdest is driven only on the output side; the input side carries untagged packets.
interface axis_tdest_scheduler_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int DEST_WIDTH = 2
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DEST_WIDTH-1:0] tdest;

    modport master (output tdata, tkeep, tvalid, tlast, tdest, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_tdest_scheduler.sv
// Per-packet round-robin destination picker with a registered main+skid output stage
// and per-destination packet counters.
module axis_tdest_scheduler #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int AXIS_DEST_WIDTH = 2,
    parameter int NUM_DEST        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_tdest_scheduler_if.slave     s_axis_sched,
    axis_tdest_scheduler_if.master    m_axis_sched,
    input  logic [NUM_DEST-1:0]       dest_enable,
    input  logic [NUM_DEST-1:0]       dest_full,
    output logic [NUM_DEST*16-1:0]    stat_pkt_count,
    output logic                      busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    localparam logic [AXIS_DEST_WIDTH-1:0] LAST_IDX = AXIS_DEST_WIDTH'(NUM_DEST - 1);
    localparam logic [AXIS_DEST_WIDTH-1:0] IDX_ONE  = AXIS_DEST_WIDTH'(1);
    localparam logic [AXIS_DEST_WIDTH-1:0] IDX_ZERO = '0;

    logic [0:0]                 state;
    logic [AXIS_DEST_WIDTH-1:0] cur_dest;
    logic [AXIS_DEST_WIDTH-1:0] last_dest;

    logic                       main_valid;
    logic [AXIS_DATA_WIDTH-1:0] main_data;
    logic [AXIS_KEEP_WIDTH-1:0] main_keep;
    logic                       main_last;
    logic [AXIS_DEST_WIDTH-1:0] main_dest;

    logic                       skid_valid;
    logic [AXIS_DATA_WIDTH-1:0] skid_data;
    logic [AXIS_KEEP_WIDTH-1:0] skid_keep;
    logic                       skid_last;
    logic [AXIS_DEST_WIDTH-1:0] skid_dest;

    logic [NUM_DEST*16-1:0]     pkt_cnt;

    logic                       s_ready;
    logic                       s_accept;
    logic                       m_take;
    logic                       main_load_ok;
    logic                       pick_found;
    logic [AXIS_DEST_WIDTH-1:0] pick;
    logic [AXIS_DEST_WIDTH-1:0] probe;

    // Search starts one past the previous winner and wraps by compare, so no index >= NUM_DEST appears.
    // NOTE: blocking '=' in always_comb lets probe advance step by step through the loop.
    always_comb begin
        pick_found = 1'b0;
        pick       = IDX_ZERO;
        probe      = last_dest;
        for (int i = 0; i < NUM_DEST; i++) begin
            probe = (probe == LAST_IDX) ? IDX_ZERO : probe + IDX_ONE;
            if (!pick_found && dest_enable[probe] && !dest_full[probe]) begin
                pick_found = 1'b1;
                pick       = probe;
            end
        end
    end

    assign s_ready      = (state == PASS) && !skid_valid;
    assign s_accept     = s_ready && s_axis_sched.tvalid;
    assign m_take       = main_valid && m_axis_sched.tready;
    assign main_load_ok = !main_valid || m_axis_sched.tready;

    // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_dest  <= IDX_ZERO;
            last_dest <= LAST_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_sched.tvalid && pick_found) begin
                        cur_dest  <= pick;
                        last_dest <= pick;
                        state     <= PASS;
                    end
                end
                PASS: begin
                    if (s_accept && s_axis_sched.tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid only fills while main is stalled; it always drains into main before new beats enter.
    // NOTE: the data registers are reset as well, since tdata/tkeep must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_keep  <= '0;
            main_last  <= 1'b0;
            main_dest  <= IDX_ZERO;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
            skid_dest  <= IDX_ZERO;
        end else if (main_load_ok) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_keep  <= skid_keep;
                main_last  <= skid_last;
                main_dest  <= skid_dest;
                skid_valid <= 1'b0;
            end else if (s_accept) begin
                main_valid <= 1'b1;
                main_data  <= s_axis_sched.tdata;
                main_keep  <= s_axis_sched.tkeep;
                main_last  <= s_axis_sched.tlast;
                main_dest  <= cur_dest;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (s_accept) begin
            skid_valid <= 1'b1;
            skid_data  <= s_axis_sched.tdata;
            skid_keep  <= s_axis_sched.tkeep;
            skid_last  <= s_axis_sched.tlast;
            skid_dest  <= cur_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (m_take && main_last) begin
            for (int i = 0; i < NUM_DEST; i++) begin
                if (main_dest == AXIS_DEST_WIDTH'(i)) begin
                    pkt_cnt[16*i +: 16] <= pkt_cnt[16*i +: 16] + 16'd1;
                end
            end
        end
    end

    assign s_axis_sched.tready = s_ready;

    assign m_axis_sched.tvalid = main_valid;
    assign m_axis_sched.tdata  = main_data;
    assign m_axis_sched.tkeep  = main_keep;
    assign m_axis_sched.tlast  = main_last;
    assign m_axis_sched.tdest  = main_dest;

    assign stat_pkt_count = pkt_cnt;
    assign busy           = (state == PASS);
endmodule
